// File: rtl/sd_read_sched.sv
// sd_read_sched: two-requester round-robin SD sector reader.
// Issues CMD17, waits for R1, polls for the 0xFE start token, streams 512
// data bytes out tagged with the owning requester, then drops the 2 CRC bytes.
module sd_read_sched #(
  parameter int TOKEN_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        boot_done,
  input  logic [1:0]  req,
  input  logic [22:0] sector0,
  input  logic [22:0] sector1,
  output logic [1:0]  gnt,
  output logic [6:0]  cmd,
  output logic [31:0] arg,
  output logic        SDctrl_start,
  input  logic        SDctrl_available,
  input  logic        SDctrl_valid_status,
  input  logic [6:0]  SDctrl_status,
  output logic        byte_req,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [7:0]  dout,
  output logic        dout_valid,
  output logic        dout_id,
  output logic        dout_last,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        busy
);

  localparam logic [15:0] POLL_LAST = 16'(TOKEN_TIMEOUT - 1);
  localparam logic [6:0]  CMD17     = 7'h11;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_R1, S_WAIT_TOKEN, S_DATA, S_CRC, S_DONE, S_ERR
  } state_t;

  state_t      state, state_nxt;
  logic        last_ptr;   // requester served most recently
  logic [15:0] poll_cnt;   // 0xFF polls seen while waiting for the token
  logic [8:0]  data_cnt;   // data byte index 0..511
  logic        crc_cnt;    // 0 = first CRC byte pending, 1 = second
  logic        grant_go;
  logic        win;
  logic        tok_start;
  logic        tok_idle;

  assign grant_go  = boot_done && SDctrl_available && (req != 2'b00);
  // Tie goes to whoever was not served last; otherwise the lone requester.
  assign win       = (req == 2'b11) ? ~last_ptr : req[1];
  assign tok_start = (byte_in == 8'hFE);
  assign tok_idle  = (byte_in == 8'hFF);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; stray strobes outside their owning states fall through
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:       if (grant_go) state_nxt = S_WAIT_R1;
      S_WAIT_R1:    if (SDctrl_valid_status)
                      state_nxt = (SDctrl_status == 7'd0) ? S_WAIT_TOKEN : S_ERR;
      S_WAIT_TOKEN: if (byte_valid) begin
                      if (tok_start)     state_nxt = S_DATA;
                      else if (tok_idle) state_nxt = (poll_cnt == POLL_LAST) ? S_ERR : S_WAIT_TOKEN;
                      else               state_nxt = S_ERR;
                    end
      S_DATA:       if (byte_valid && data_cnt == 9'd511) state_nxt = S_CRC;
      S_CRC:        if (byte_valid && crc_cnt) state_nxt = S_DONE;
      S_DONE:       state_nxt = S_IDLE;
      S_ERR:        state_nxt = S_IDLE;
      default:      state_nxt = S_IDLE;
    endcase
  end

  // State-decoded status outputs
  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE);
    err  = (state == S_ERR);
  end

  // Registered command, byte-request and data path
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt          <= 2'b00;
      cmd          <= 7'd0;
      arg          <= 32'd0;
      SDctrl_start <= 1'b0;
      byte_req     <= 1'b0;
      dout         <= 8'd0;
      dout_valid   <= 1'b0;
      dout_id      <= 1'b0;
      dout_last    <= 1'b0;
      err_code     <= 2'd0;
      last_ptr     <= 1'b1;
      poll_cnt     <= 16'd0;
      data_cnt     <= 9'd0;
      crc_cnt      <= 1'b0;
    end else begin
      gnt          <= 2'b00;
      SDctrl_start <= 1'b0;
      byte_req     <= 1'b0;
      dout_valid   <= 1'b0;
      dout_last    <= 1'b0;
      case (state)
        S_IDLE: if (grant_go) begin
          gnt          <= {win, ~win};
          SDctrl_start <= 1'b1;
          cmd          <= CMD17;
          arg          <= {(win ? sector1 : sector0), 9'd0};
          dout_id      <= win;
          last_ptr     <= win;
          poll_cnt     <= 16'd0;
          data_cnt     <= 9'd0;
          crc_cnt      <= 1'b0;
        end
        S_WAIT_R1: if (SDctrl_valid_status) begin
          if (SDctrl_status == 7'd0) byte_req <= 1'b1;
          else                       err_code <= 2'd1;
        end
        S_WAIT_TOKEN: if (byte_valid) begin
          if (tok_start) begin
            byte_req <= 1'b1;
          end else if (tok_idle) begin
            poll_cnt <= poll_cnt + 16'd1;
            if (poll_cnt == POLL_LAST) err_code <= 2'd2;
            else                       byte_req <= 1'b1;
          end else begin
            err_code <= 2'd3;
          end
        end
        // The request after byte 511 fetches the first CRC byte.
        S_DATA: if (byte_valid) begin
          dout       <= byte_in;
          dout_valid <= 1'b1;
          dout_last  <= (data_cnt == 9'd511);
          data_cnt   <= data_cnt + 9'd1;
          byte_req   <= 1'b1;
        end
        S_CRC: if (byte_valid) begin
          crc_cnt <= 1'b1;
          if (!crc_cnt) byte_req <= 1'b1;
        end
        // Command fields stay up for the whole transfer and clear on the way back to IDLE.
        S_DONE, S_ERR: begin
          cmd <= 7'd0;
          arg <= 32'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_read_sched.sv
// tb_sd_read_sched: randomized bench with a behavioural card model and
// transfer-level expectations derived from the read-scheduler rules.
module tb_sd_read_sched;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        boot_done;
  logic [1:0]  req;
  logic [22:0] sector0, sector1;
  logic [1:0]  gnt;
  logic [6:0]  cmd;
  logic [31:0] arg;
  logic        SDctrl_start;
  logic        SDctrl_available;
  logic        SDctrl_valid_status;
  logic [6:0]  SDctrl_status;
  logic        byte_req;
  logic        byte_valid;
  logic [7:0]  byte_in;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        dout_id;
  logic        dout_last;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic        busy;

  int         n_chk = 0;
  int         n_fail = 0;
  int         gen = 0;          // bumped per transfer / reset so stale card replies are dropped
  logic       last_srv = 1'b1;  // model of the last-served requester
  logic [6:0] r1_val = 7'd0;
  logic [7:0] card_q[$];        // bytes the card returns, in order
  int         g_b, d_b, rd_ptr, seen_gen, g_r, d_r;

  sd_read_sched #(.TOKEN_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .boot_done(boot_done), .req(req),
    .sector0(sector0), .sector1(sector1), .gnt(gnt), .cmd(cmd), .arg(arg),
    .SDctrl_start(SDctrl_start), .SDctrl_available(SDctrl_available),
    .SDctrl_valid_status(SDctrl_valid_status), .SDctrl_status(SDctrl_status),
    .byte_req(byte_req), .byte_valid(byte_valid), .byte_in(byte_in),
    .dout(dout), .dout_valid(dout_valid), .dout_id(dout_id), .dout_last(dout_last),
    .done(done), .err(err), .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {5'd0, gnt, cmd, arg, SDctrl_start, byte_req, dout, dout_valid,
            dout_id, dout_last, done, err, err_code, busy};
  endfunction

  // Card R1 responder: answers each command start after 1..3 cycles
  initial begin
    SDctrl_valid_status = 1'b0;
    SDctrl_status = 7'd0;
    forever begin
      @(negedge clk);
      if (SDctrl_start) begin
        g_r = gen;
        d_r = $urandom_range(0, 2);
        @(posedge clk);
        repeat (d_r) @(posedge clk);
        #1;
        if (g_r == gen) begin
          SDctrl_status = r1_val;
          SDctrl_valid_status = 1'b1;
          @(posedge clk); #1;
          SDctrl_valid_status = 1'b0;
        end
      end
    end
  end

  // Card byte responder: one byte per request, 0xFF once the script runs dry
  initial begin
    byte_valid = 1'b0;
    byte_in = 8'd0;
    rd_ptr = 0;
    seen_gen = -1;
    forever begin
      @(negedge clk);
      if (byte_req) begin
        g_b = gen;
        d_b = $urandom_range(0, 2);
        @(posedge clk);
        repeat (d_b) @(posedge clk);
        #1;
        if (g_b == gen) begin
          if (g_b != seen_gen) begin rd_ptr = 0; seen_gen = g_b; end
          byte_in = (rd_ptr < card_q.size()) ? card_q[rd_ptr] : 8'hFF;
          rd_ptr++;
          byte_valid = 1'b1;
          @(posedge clk); #1;
          byte_valid = 1'b0;
        end
      end
    end
  end

  // One requester transaction, from request to back-in-IDLE.
  task automatic run_txn(input logic [1:0] rq, input logic [22:0] s0, input logic [22:0] s1,
                         input logic [6:0] r1, input int nff, input logic [7:0] tok,
                         input bit cnt_pat, input int drop_at, input bit drop_boot,
                         input int abort_at);
    logic       w;
    logic [7:0] exp_data[512];
    int exp_kind, exp_breq, ngnt, nbr, beats, nbad, nlast, lastidx, cyc, got_kind;
    logic id;
    bit   fin;
    ngnt = 0; nbr = 0; beats = 0; nbad = 0; nlast = 0; lastidx = -1; id = 1'b0;
    w = (rq == 2'b11) ? ~last_srv : rq[1];
    for (int i = 0; i < 512; i++) exp_data[i] = cnt_pat ? 8'(i) : 8'($urandom);
    gen++;
    sector0 = s0; sector1 = s1; r1_val = r1;
    card_q.delete();
    if (r1 != 7'd0) begin
      exp_kind = 1; exp_breq = 0;
    end else if (nff >= TO) begin
      exp_kind = 2; exp_breq = TO;
    end else begin
      for (int i = 0; i < nff; i++) card_q.push_back(8'hFF);
      card_q.push_back(tok);
      if (tok == 8'hFE) begin
        exp_kind = 0; exp_breq = nff + 515;
        for (int i = 0; i < 512; i++) card_q.push_back(exp_data[i]);
        card_q.push_back(8'($urandom));
        card_q.push_back(8'($urandom));
      end else begin
        exp_kind = 3; exp_breq = nff + 1;
      end
    end
    req = rq;
    fin = 1'b0; cyc = 0;
    while (!fin && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (gnt != 2'b00) begin
        ngnt++;
        chk("gnt", 64'(gnt), w ? 64'd2 : 64'd1);
        chk("start", 64'(SDctrl_start), 64'd1);
        chk("cmd_arg", {25'd0, cmd, arg}, {25'd0, 7'h11, (w ? s1 : s0), 9'd0});
      end
      if (byte_req) nbr++;
      if (dout_valid) begin
        if (beats == 0) id = dout_id;
        if (beats < 512 && dout != exp_data[beats]) nbad++;
        if (dout_last) begin nlast++; lastidx = beats; end
        beats++;
        if (beats == drop_at) req = 2'b00;
        if (drop_boot && beats == 100) boot_done = 1'b0;
        if (beats == abort_at) begin
          rst = 1'b1;
          @(negedge clk);
          chk("reset_outputs", outs(), 64'd0);
          rst = 1'b0;
          gen++;
          last_srv = 1'b1;
          return;
        end
      end
      if (done || err) fin = 1'b1;
    end
    if (!fin) begin
      chk("completion_timeout", 64'd0, 64'd1);
      boot_done = 1'b1;
      return;
    end
    last_srv = w;
    got_kind = done ? 0 : (err ? int'(err_code) : 7);
    chk("grants", 64'(ngnt), 64'd1);
    chk("result", 64'(got_kind), 64'(exp_kind));
    chk("byte_reqs", 64'(nbr), 64'(exp_breq));
    chk("beats", 64'(beats), (exp_kind == 0) ? 64'd512 : 64'd0);
    if (exp_kind == 0) begin
      chk("data_bad", 64'(nbad), 64'd0);
      chk("last_beat", {32'(nlast), 32'(lastidx)}, {32'd1, 32'd511});
      chk("dout_id", 64'(id), 64'(w));
    end
    boot_done = 1'b1;
    @(negedge clk);
    chk("back_to_idle", {61'd0, busy, done, err}, 64'd0);
  endtask

  initial begin
    int         ng;
    logic [1:0] rq;
    logic [6:0] r1;
    logic [7:0] tok;
    logic [22:0] s;
    rst = 1'b1; boot_done = 1'b0; req = 2'b00; SDctrl_available = 1'b1;
    sector0 = 23'd0; sector1 = 23'd0;
    repeat (3) @(negedge clk);
    chk("reset_state", outs(), 64'd0);
    rst = 1'b0;

    // No grant while card init is pending or the controller is busy
    req = 2'b01; ng = 0;
    repeat (8) begin @(negedge clk); if (gnt != 2'b00 || busy) ng++; end
    chk("no_grant_before_boot", 64'(ng), 64'd0);
    boot_done = 1'b1; SDctrl_available = 1'b0; ng = 0;
    repeat (6) begin @(negedge clk); if (gnt != 2'b00 || busy) ng++; end
    chk("no_grant_unavailable", 64'(ng), 64'd0);
    SDctrl_available = 1'b1;

    // Both requesting continuously: 01, 10, 01
    repeat (3) run_txn(2'b11, 23'($urandom), 23'($urandom), 7'd0, 1, 8'hFE, 1'b0, -1, 1'b0, -1);
    // Req0 alone, sector 3, counting data pattern
    run_txn(2'b01, 23'h000003, 23'($urandom), 7'd0, 2, 8'hFE, 1'b1, -1, 1'b0, -1);
    // R1 error, then next request served
    run_txn(2'b10, 23'($urandom), 23'($urandom), 7'h04, 0, 8'hFE, 1'b0, -1, 1'b0, -1);
    // Card never sends a token
    run_txn(2'b01, 23'($urandom), 23'($urandom), 7'd0, TO, 8'hFE, 1'b0, -1, 1'b0, -1);
    // Data error token
    run_txn(2'b10, 23'($urandom), 23'($urandom), 7'd0, 1, 8'h09, 1'b0, -1, 1'b0, -1);

    // Randomized mix
    for (int t = 0; t < 8; t++) begin
      rq  = 2'($urandom_range(1, 3));
      r1  = ($urandom_range(0, 4) == 0) ? 7'($urandom_range(1, 127)) : 7'd0;
      tok = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 253)) : 8'hFE;
      run_txn(rq, 23'($urandom), 23'($urandom), r1, $urandom_range(0, 5), tok, 1'b0,
              ($urandom_range(0, 3) == 0) ? 50 : -1, 1'($urandom_range(0, 1)), -1);
    end

    // Reset in the middle of the data phase, then a clean full re-read
    s = 23'($urandom);
    run_txn(2'b01, s, 23'($urandom), 7'd0, 1, 8'hFE, 1'b0, -1, 1'b0, 200);
    run_txn(2'b01, s, 23'($urandom), 7'd0, 0, 8'hFE, 1'b0, -1, 1'b0, -1);

    req = 2'b00;
    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_read_sched.md
# sd_read_sched

Single-block read scheduler for the SD card path. Arbitrates round-robin between two sector-read requesters (e.g. wavetable loader, MIDI file player), drives the SD command controller to issue CMD17, polls the byte-level SPI interface for the start token, streams the 512 data bytes back tagged with the requester ID, and discards the CRC. Sits between the SD command/SPI controller and the sample and sequence loaders; only active once the boot sequencer has finished card init.

## Interface
- TOKEN_TIMEOUT, 1024, max 0xFF byte polls while waiting for the start token before error (range 2..65535)

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- boot_done  in  1  card init complete; level
- req  in  2  per-requester read request; level, held until own done/err
- sector0, sector1  in  23 each  sector number per requester; stable while req high
- gnt  out  2  one-hot grant pulse, 1 cycle
- cmd  out  7  command index to SD controller
- arg  out  32  command argument
- SDctrl_start  out  1  command start pulse, 1 cycle
- SDctrl_available  in  1  controller idle and able to accept a command
- SDctrl_valid_status  in  1  R1 status strobe
- SDctrl_status  in  7  R1 status bits
- byte_req  out  1  pulse: clock one byte (0xFF out) on SPI
- byte_valid  in  1  received byte strobe
- byte_in  in  8  received byte
- dout  out  8  data byte
- dout_valid  out  1  data byte strobe
- dout_id  out  1  requester owning current transfer
- dout_last  out  1  with dout_valid on byte 511
- done  out  1  transfer complete pulse
- err  out  1  transfer failed pulse
- err_code  out  2  1 = R1 nonzero, 2 = token timeout, 3 = data error token; held until next err
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, WAIT_R1, WAIT_TOKEN, DATA, CRC, DONE, ERR.
- IDLE: when boot_done && SDctrl_available && req != 0: pick winner, load cmd = 7'h11, arg = {sectorN, 9'b0} (byte addressing), pulse SDctrl_start and gnt[N], set dout_id = N, go WAIT_R1.
- Arbitration: round-robin on last-served pointer. Both requesting -> grant the one not last served. Single request -> grant it. Pointer updated at grant. After reset, requester 0 wins a tie.
- WAIT_R1: on SDctrl_valid_status: status == 0 -> WAIT_TOKEN and issue first byte_req; else -> ERR, code 1.
- WAIT_TOKEN: each byte_valid: 0xFE -> DATA; 0xFF -> poll counter +1, and at TOKEN_TIMEOUT polls -> ERR, code 2; any other value -> ERR, code 3. Otherwise issue the next byte_req.
- DATA: 9-bit counter. Forward each byte to dout. Count 511 -> dout_last and go CRC. Otherwise issue the next byte_req.
- CRC: read 2 bytes and discard them; after the second -> DONE.
- DONE: pulse done, go IDLE. ERR: pulse err, go IDLE.
- Exactly one byte_req outstanding at a time.
- byte_valid outside WAIT_TOKEN/DATA/CRC: ignored. SDctrl_valid_status outside WAIT_R1: ignored.
- Requester dropping req mid-transfer: transfer still runs to DONE/ERR; next arbitration sees the new req.
- boot_done falling mid-transfer: no effect until return to IDLE.

## Timing
- Reset values: all outputs 0, state IDLE, pointer = 1, counters 0, err_code 0.
- Grant decision sampled in cycle N. SDctrl_start, gnt, cmd and arg are valid in cycle N+1. cmd and arg are held until IDLE is re-entered.
- R1 accepted in cycle M: byte_req in cycle M+1.
- byte_valid in cycle K: next byte_req in K+1 when more bytes are due. dout, dout_valid and dout_last are registered and appear in K+1.
- Second CRC byte_valid in cycle K: done in K+1 (state DONE), IDLE in K+2. Earliest new grant decision is in K+2.
- Error detected in cycle K: err and err_code in K+1, IDLE in K+2.
- rst high in any state: all of the above reset values apply on the next cycle. An in-flight byte_valid is discarded.

## Test plan
- Req0 alone, sector0 = 0x000003, R1 = 0, tokens FF,FF,FE, data 0..255,0..255, CRC: cmd 0x11, arg 0x00000600, gnt = 01, 512 dout beats in order, dout_last on beat 512 only, done once, dout_id = 0.
- req = 11 held continuously for three transfers: grants 01, 10, 01. Each grant waits for the previous done.
- R1 = 0x04: err with err_code 1, no byte_req issued, IDLE two cycles later, then the next request is served.
- Card returns 0xFF forever: err code 2 after exactly TOKEN_TIMEOUT byte_reqs. With TOKEN_TIMEOUT = 4, exactly 4 byte_req pulses.
- Token 0x09: err code 3, no dout_valid.
- rst asserted at data byte 200: next cycle all outputs 0. With req0 still high after reset, a fresh CMD17 is issued and the full 512 bytes are delivered.
